// File: rtl/psram_async_controller.sv
// -----------------------------------------------------------------------------
// psram_async_controller
//
// Asynchronous-mode controller for a Micron CellularRAM (PSRAM). A host issues
// single-word read, write or configuration-register-write requests over a
// valid/ready port. The controller sequences ce/oe/we/lb/ub/cre from cycle
// counters and returns a one-cycle response strobe, with read data, once each
// access completes.
//
// Ports
//   clk, resetN                 clock (rising edge) and async active-low reset
//   reqValid/reqReady           host request handshake
//   reqWrite, reqCfg            1 = write / 1 = config write (reqCfg wins)
//   reqAddr, reqWdata, reqBe    word address (or config value), data, byte enables
//   rspValid, rspData           completion strobe and last read data
//   ramWait                     mt_wait after a two-flop synchroniser
//   mt_*                        PSRAM pins (strobes active low)
//
// Sequence: INIT (power-up wait) -> IDLE -> ACCESS -> HOLD -> RECOVER -> IDLE.
// Every pin-facing output comes straight from a flop. The output logic is
// computed from the next state, so the pins change on the same edge as the
// state does.
// -----------------------------------------------------------------------------
module psram_async_controller #(
    parameter int ADDRESS_SIZE    = 23,
    parameter int DATA_SIZE       = 16,
    parameter int ACCESS_CYCLES   = 7,
    parameter int RECOVERY_CYCLES = 2,
    parameter int POWERUP_CYCLES  = 15000
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic                    reqWrite,
    input  logic                    reqCfg,
    input  logic [ADDRESS_SIZE-1:0] reqAddr,
    input  logic [DATA_SIZE-1:0]    reqWdata,
    input  logic [1:0]              reqBe,
    output logic                    rspValid,
    output logic [DATA_SIZE-1:0]    rspData,
    output logic                    ramWait,
    output logic [ADDRESS_SIZE-1:0] mt_addr,
    inout  wire  [DATA_SIZE-1:0]    mt_dq,
    output logic                    mt_ce,
    output logic                    mt_oe,
    output logic                    mt_we,
    output logic                    mt_lb,
    output logic                    mt_ub,
    output logic                    mt_clk,
    output logic                    mt_adv,
    output logic                    mt_cre,
    input  logic                    mt_wait
);

    // One shared counter serves the power-up, access and recovery phases,
    // so it is sized for the longest of them.
    localparam int CNT_MAX_AR = (ACCESS_CYCLES > RECOVERY_CYCLES) ? ACCESS_CYCLES : RECOVERY_CYCLES;
    localparam int CNT_MAX    = (POWERUP_CYCLES > CNT_MAX_AR) ? POWERUP_CYCLES : CNT_MAX_AR;
    localparam int CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ACCESS,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;

    // Request latched at accept.
    logic [ADDRESS_SIZE-1:0] addr_reg, addr_next;
    logic [DATA_SIZE-1:0]    wdata_reg, wdata_next;
    logic [1:0]              be_reg, be_next;
    logic                    write_reg, write_next;
    logic                    cfg_reg, cfg_next;

    // Registered outputs.
    logic                    ready_reg, ready_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [DATA_SIZE-1:0]    rsp_data_reg, rsp_data_next;
    logic [ADDRESS_SIZE-1:0] mt_addr_reg, mt_addr_next;
    logic                    ce_reg, ce_next;
    logic                    oe_reg, oe_next;
    logic                    we_reg, we_next;
    logic                    lb_reg, lb_next;
    logic                    ub_reg, ub_next;
    logic                    cre_reg, cre_next;
    logic                    dq_oe_reg, dq_oe_next;
    logic [DATA_SIZE-1:0]    dq_out_reg, dq_out_next;
    logic                    wait_meta_reg, wait_sync_reg;

    logic                    accept;
    logic                    read_op_next;
    logic                    read_op_reg;

    assign accept       = (state_reg == S_IDLE) && reqValid && ready_reg;
    assign read_op_next = !write_next && !cfg_next;
    assign read_op_reg  = !write_reg && !cfg_reg;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg     <= S_INIT;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            write_reg     <= 1'b0;
            cfg_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            mt_addr_reg   <= '0;
            ce_reg        <= 1'b1;
            oe_reg        <= 1'b1;
            we_reg        <= 1'b1;
            lb_reg        <= 1'b1;
            ub_reg        <= 1'b1;
            cre_reg       <= 1'b0;
            dq_oe_reg     <= 1'b0;
            dq_out_reg    <= '0;
            wait_meta_reg <= 1'b0;
            wait_sync_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            be_reg        <= be_next;
            write_reg     <= write_next;
            cfg_reg       <= cfg_next;
            ready_reg     <= ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            mt_addr_reg   <= mt_addr_next;
            ce_reg        <= ce_next;
            oe_reg        <= oe_next;
            we_reg        <= we_next;
            lb_reg        <= lb_next;
            ub_reg        <= ub_next;
            cre_reg       <= cre_next;
            dq_oe_reg     <= dq_oe_next;
            dq_out_reg    <= dq_out_next;
            wait_meta_reg <= mt_wait;
            wait_sync_reg <= wait_meta_reg;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        write_next = write_reg;
        cfg_next   = cfg_reg;

        case (state_reg)
            S_INIT: begin
                if (cnt_reg == PWR_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ACCESS;
                    cnt_next   = '0;
                    addr_next  = reqAddr;
                    wdata_next = reqWdata;
                    be_next    = reqBe;
                    write_next = reqWrite && !reqCfg;
                    cfg_next   = reqCfg;
                end
            end
            S_ACCESS: begin
                if (cnt_reg == ACC_LAST) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_HOLD: begin
                cnt_next   = '0;
                state_next = (RECOVERY_CYCLES == 0) ? S_IDLE : S_RECOVER;
            end
            S_RECOVER: begin
                if (cnt_reg == REC_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Pin values are chosen for the state being entered, so each pin flop
    // switches on the same edge as the state register.
    always_comb begin
        ready_next     = (state_next == S_IDLE);
        rsp_valid_next = (state_next == S_HOLD);
        rsp_data_next  = rsp_data_reg;
        mt_addr_next   = mt_addr_reg;
        ce_next        = 1'b1;
        oe_next        = 1'b1;
        we_next        = 1'b1;
        lb_next        = 1'b1;
        ub_next        = 1'b1;
        cre_next       = 1'b0;
        dq_oe_next     = 1'b0;
        dq_out_next    = dq_out_reg;

        // Read data is sampled on the edge that ends the last access cycle.
        if (state_reg == S_ACCESS && cnt_reg == ACC_LAST && read_op_reg) begin
            rsp_data_next = mt_dq;
        end

        case (state_next)
            S_ACCESS, S_HOLD: begin
                ce_next      = 1'b0;
                lb_next      = cfg_next ? 1'b0 : ~be_next[0];
                ub_next      = cfg_next ? 1'b0 : ~be_next[1];
                cre_next     = cfg_next;
                mt_addr_next = addr_next;
                // Data is driven only for writes, which never assert oe.
                dq_oe_next   = !read_op_next;
                dq_out_next  = wdata_next;
                if (state_next == S_ACCESS) begin
                    oe_next = !read_op_next;
                    we_next = read_op_next;
                end
            end
            default: begin
            end
        endcase
    end

    assign reqReady = ready_reg;
    assign rspValid = rsp_valid_reg;
    assign rspData  = rsp_data_reg;
    assign ramWait  = wait_sync_reg;
    assign mt_addr  = mt_addr_reg;
    assign mt_ce    = ce_reg;
    assign mt_oe    = oe_reg;
    assign mt_we    = we_reg;
    assign mt_lb    = lb_reg;
    assign mt_ub    = ub_reg;
    assign mt_cre   = cre_reg;
    assign mt_dq    = dq_oe_reg ? dq_out_reg : {DATA_SIZE{1'bz}};

    // The clock and address-valid pins stay low in asynchronous mode.
    assign mt_clk   = 1'b0;
    assign mt_adv   = 1'b0;

endmodule

// File: tb/tb_psram_async_controller.sv
// -----------------------------------------------------------------------------
// tb_psram_async_controller
//
// Instance A uses the default timing and runs a table of host requests against
// a small PSRAM pin model. Instance B uses the shortest timing (one access
// cycle, no recovery). Responses are checked against a scoreboard of expected
// {kind, data, due cycle} records.
// -----------------------------------------------------------------------------
module tb_psram_async_controller;

    localparam int AC_A = 7;
    localparam int RC_A = 2;
    localparam int PU_A = 15000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- instance A
    logic        a_resetN, a_reqValid, a_reqReady, a_reqWrite, a_reqCfg;
    logic [22:0] a_reqAddr;
    logic [15:0] a_reqWdata, a_rspData;
    logic [1:0]  a_reqBe;
    logic        a_rspValid, a_ramWait, a_mt_wait;
    logic [22:0] a_mt_addr;
    wire  [15:0] a_mt_dq;
    logic        a_mt_ce, a_mt_oe, a_mt_we, a_mt_lb, a_mt_ub, a_mt_clk, a_mt_adv, a_mt_cre;

    psram_async_controller #(
        .ADDRESS_SIZE(23), .DATA_SIZE(16), .ACCESS_CYCLES(AC_A),
        .RECOVERY_CYCLES(RC_A), .POWERUP_CYCLES(PU_A)
    ) dut_a (
        .clk(clk), .resetN(a_resetN), .reqValid(a_reqValid), .reqReady(a_reqReady),
        .reqWrite(a_reqWrite), .reqCfg(a_reqCfg), .reqAddr(a_reqAddr), .reqWdata(a_reqWdata),
        .reqBe(a_reqBe), .rspValid(a_rspValid), .rspData(a_rspData), .ramWait(a_ramWait),
        .mt_addr(a_mt_addr), .mt_dq(a_mt_dq), .mt_ce(a_mt_ce), .mt_oe(a_mt_oe), .mt_we(a_mt_we),
        .mt_lb(a_mt_lb), .mt_ub(a_mt_ub), .mt_clk(a_mt_clk), .mt_adv(a_mt_adv),
        .mt_cre(a_mt_cre), .mt_wait(a_mt_wait)
    );

    // PSRAM model A: drives a word while ce & oe are low, writes enabled
    // bytes on every clock while ce & we are low.
    logic [15:0] mem_a [0:1023];
    logic [22:0] cfg_a;
    assign a_mt_dq = (!a_mt_ce && !a_mt_oe && a_mt_we) ? mem_a[a_mt_addr[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (cyc < 2) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= 16'h0000;
            cfg_a <= '0;
        end else if (!a_mt_ce && !a_mt_we) begin
            if (a_mt_cre) cfg_a <= a_mt_addr;
            else begin
                if (!a_mt_lb) mem_a[a_mt_addr[9:0]][7:0]  <= a_mt_dq[7:0];
                if (!a_mt_ub) mem_a[a_mt_addr[9:0]][15:8] <= a_mt_dq[15:8];
            end
        end
    end

    // ---------------------------------------------------------------- instance B
    logic        b_resetN, b_reqValid, b_reqReady, b_reqWrite, b_reqCfg;
    logic [22:0] b_reqAddr;
    logic [15:0] b_reqWdata, b_rspData;
    logic [1:0]  b_reqBe;
    logic        b_rspValid, b_ramWait, b_mt_wait;
    logic [22:0] b_mt_addr;
    wire  [15:0] b_mt_dq;
    logic        b_mt_ce, b_mt_oe, b_mt_we, b_mt_lb, b_mt_ub, b_mt_clk, b_mt_adv, b_mt_cre;

    psram_async_controller #(
        .ADDRESS_SIZE(23), .DATA_SIZE(16), .ACCESS_CYCLES(1),
        .RECOVERY_CYCLES(0), .POWERUP_CYCLES(20)
    ) dut_b (
        .clk(clk), .resetN(b_resetN), .reqValid(b_reqValid), .reqReady(b_reqReady),
        .reqWrite(b_reqWrite), .reqCfg(b_reqCfg), .reqAddr(b_reqAddr), .reqWdata(b_reqWdata),
        .reqBe(b_reqBe), .rspValid(b_rspValid), .rspData(b_rspData), .ramWait(b_ramWait),
        .mt_addr(b_mt_addr), .mt_dq(b_mt_dq), .mt_ce(b_mt_ce), .mt_oe(b_mt_oe), .mt_we(b_mt_we),
        .mt_lb(b_mt_lb), .mt_ub(b_mt_ub), .mt_clk(b_mt_clk), .mt_adv(b_mt_adv),
        .mt_cre(b_mt_cre), .mt_wait(b_mt_wait)
    );

    logic [15:0] mem_b [0:15];
    assign b_mt_dq = (!b_mt_ce && !b_mt_oe && b_mt_we) ? mem_b[b_mt_addr[3:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (cyc < 2) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= 16'h0000;
        end else if (!b_mt_ce && !b_mt_we && !b_mt_cre) begin
            if (!b_mt_lb) mem_b[b_mt_addr[3:0]][7:0]  <= b_mt_dq[7:0];
            if (!b_mt_ub) mem_b[b_mt_addr[3:0]][15:8] <= b_mt_dq[15:8];
        end
    end

    // ---------------------------------------------------------------- bus monitor
    // oe and we never low together; no unknown data while oe is low (would mean
    // both sides drive); bus released whenever ce is high.
    always @(negedge clk) begin
        if (cyc > 2) begin
            viol <= viol
                + ((a_resetN && !a_mt_oe && !a_mt_we) ? 1 : 0)
                + ((a_resetN && !a_mt_oe && $isunknown(a_mt_dq)) ? 1 : 0)
                + ((a_mt_ce && a_mt_dq !== 16'hzzzz) ? 1 : 0)
                + ((b_resetN && !b_mt_oe && !b_mt_we) ? 1 : 0)
                + ((b_resetN && !b_mt_oe && $isunknown(b_mt_dq)) ? 1 : 0)
                + ((b_mt_ce && b_mt_dq !== 16'hzzzz) ? 1 : 0);
        end
    end

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        logic        rd;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    exp_t got;
    always @(negedge clk) begin
        if (a_resetN && a_rspValid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                chk("rsp_cycle", cyc, got.due);
                if (got.rd) chk("rsp_data", {16'h0, a_rspData}, {16'h0, got.data});
            end
        end
    end

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic        wr;
        logic        cfg;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp;   // expected read data (reads only)
    } vec_t;

    vec_t tbl [0:9];

    task automatic check_reset(input string tag);
        chk({tag, "_ce"},  a_mt_ce, 1);
        chk({tag, "_oe"},  a_mt_oe, 1);
        chk({tag, "_we"},  a_mt_we, 1);
        chk({tag, "_lb"},  a_mt_lb, 1);
        chk({tag, "_ub"},  a_mt_ub, 1);
        chk({tag, "_cre"}, a_mt_cre, 0);
        chk({tag, "_clk"}, a_mt_clk, 0);
        chk({tag, "_adv"}, a_mt_adv, 0);
        chk({tag, "_addr"}, a_mt_addr, 0);
        chk({tag, "_dq_z"}, {16'h0, a_mt_dq}, {16'h0, 16'hzzzz});
        chk({tag, "_ready"}, a_reqReady, 0);
        chk({tag, "_rspv"}, a_rspValid, 0);
        chk({tag, "_rspd"}, a_rspData, 0);
        chk({tag, "_wait"}, a_ramWait, 0);
    endtask

    // reqValid is held high through power-up; nothing may be accepted early.
    task automatic powerup_check(input string tag);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        a_reqValid = 1'b1;
        a_reqWrite = 1'b1;
        a_reqCfg   = 1'b0;
        a_reqAddr  = 23'h55;
        while (!a_reqReady && n < PU_A + 20) begin
            @(posedge clk);
            #1;
            n++;
            if (!a_mt_ce || a_rspValid) bad++;
        end
        a_reqValid = 1'b0;
        chk({tag, "_powerup_cycles"}, n, PU_A);
        chk({tag, "_init_quiet"}, bad, 0);
    endtask

    task automatic wait_ready_a(output logic ok);
        int g;
        g = 0;
        @(negedge clk);
        while (!a_reqReady && g < 200) begin
            @(negedge clk);
            g++;
        end
        ok = a_reqReady;
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input vec_t v);
        logic ok, rd, lb_e, ub_e;
        int   n;
        rd   = !v.wr && !v.cfg;
        lb_e = v.cfg ? 1'b0 : ~v.be[0];
        ub_e = v.cfg ? 1'b0 : ~v.be[1];
        wait_ready_a(ok);
        if (ok) begin
            a_reqValid = 1'b1;
            a_reqWrite = v.wr;
            a_reqCfg   = v.cfg;
            a_reqAddr  = v.addr;
            a_reqWdata = v.wdata;
            a_reqBe    = v.be;
            @(posedge clk);
            #1;
            n = cyc;
            // Response is due in the HOLD cycle, AC edges after the accept edge.
            sb.push_back('{rd, v.exp, n + AC_A});
            // Scramble the request lines: the controller must use latched values.
            a_reqValid = 1'b0;
            a_reqAddr  = 23'($urandom);
            a_reqWdata = 16'($urandom);
            a_reqBe    = 2'($urandom);
            a_reqWrite = 1'($urandom);
            a_reqCfg   = 1'($urandom);
            for (int k = 1; k <= AC_A + 1; k++) begin
                @(negedge clk);
                chk("ce", a_mt_ce, 0);
                chk("oe", a_mt_oe, (rd && k <= AC_A) ? 0 : 1);
                chk("we", a_mt_we, (!rd && k <= AC_A) ? 0 : 1);
                chk("lb", a_mt_lb, lb_e);
                chk("ub", a_mt_ub, ub_e);
                chk("cre", a_mt_cre, v.cfg);
                chk("addr", a_mt_addr, v.addr);
                if (!rd) chk("dq_drive", a_mt_dq, v.wdata);
            end
            @(negedge clk);
            chk("recover_ce", a_mt_ce, 1);
            chk("recover_dq_z", {16'h0, a_mt_dq}, {16'h0, 16'hzzzz});
            chk("recover_ready", a_reqReady, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc [0:2];
        int   ce_gap;
        int   g;
        int   n;
        logic ok;

        tbl[0] = '{1'b1, 1'b0, 23'h000123, 16'hBEEF, 2'b11, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 23'h000123, 16'h0000, 2'b11, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b0, 23'h000123, 16'h12AB, 2'b01, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 23'h000123, 16'h0000, 2'b11, 16'hBEAB};
        tbl[4] = '{1'b1, 1'b0, 23'h000123, 16'hFFFF, 2'b00, 16'h0000};
        tbl[5] = '{1'b0, 1'b0, 23'h000123, 16'h0000, 2'b11, 16'hBEAB};
        tbl[6] = '{1'b1, 1'b0, 23'h000045, 16'hCAFE, 2'b11, 16'h0000};
        tbl[7] = '{1'b1, 1'b0, 23'h000045, 16'h7700, 2'b10, 16'h0000};
        tbl[8] = '{1'b0, 1'b0, 23'h000045, 16'h0000, 2'b11, 16'h77FE};
        tbl[9] = '{1'b0, 1'b1, 23'h000010, 16'h0000, 2'b00, 16'h0000};

        a_reqValid = 0; a_reqWrite = 0; a_reqCfg = 0; a_reqAddr = 0; a_reqWdata = 0; a_reqBe = 0;
        a_mt_wait  = 0;
        b_reqValid = 0; b_reqWrite = 0; b_reqCfg = 0; b_reqAddr = 0; b_reqWdata = 0; b_reqBe = 0;
        b_mt_wait  = 0;
        a_resetN = 1'b1;
        b_resetN = 1'b1;
        #1;
        a_resetN = 1'b0;
        b_resetN = 1'b0;
        #1;
        check_reset("reset");
        repeat (3) @(negedge clk);
        a_resetN = 1'b1;
        b_resetN = 1'b1;
        powerup_check("first");

        // ramWait: two-flop delay of mt_wait.
        @(negedge clk);
        a_mt_wait = 1'b1;
        @(posedge clk); #1;
        chk("ramwait_1flop", a_ramWait, 0);
        @(posedge clk); #1;
        chk("ramwait_2flop", a_ramWait, 1);
        a_mt_wait = 1'b0;

        // Table of single requests (T2, T3, byte-enable no-op, T5).
        for (int i = 0; i < 10; i++) begin
            do_req(tbl[i]);
            $display("[TB] vec %0d wr=%0b cfg=%0b addr=%h wdata=%h be=%b exp=%h", i,
                     tbl[i].wr, tbl[i].cfg, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp);
        end
        repeat (12) @(negedge clk);
        chk("cfg_value", cfg_a, 23'h000010);

        // T4: reqValid held high for three writes; accepts spaced AC+RC+2.
        @(negedge clk);
        a_reqValid = 1'b1;
        a_reqWrite = 1'b1;
        a_reqCfg   = 1'b0;
        a_reqBe    = 2'b11;
        a_reqAddr  = 23'h200;
        a_reqWdata = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            g      = 0;
            ce_gap = 0;
            while (!a_reqReady && g < 100) begin
                if (a_mt_ce) ce_gap++;
                @(negedge clk);
                g++;
            end
            if (i > 0) chk("b2b_ce_high_recover", ce_gap, RC_A);
            @(posedge clk); #1;
            acc[i] = cyc;
            sb.push_back('{1'b0, 16'h0000, cyc + AC_A});
            $display("[TB] b2b accept %0d at cyc %0d addr=%h data=%h", i, cyc, a_reqAddr, a_reqWdata);
            a_reqAddr  = 23'h200 + 23'(i + 1);
            a_reqWdata = 16'h1111 * 16'(i + 2);
            @(negedge clk);
        end
        a_reqValid = 1'b0;
        chk("b2b_spacing_01", acc[1] - acc[0], AC_A + RC_A + 2);
        chk("b2b_spacing_12", acc[2] - acc[1], AC_A + RC_A + 2);
        do_req('{1'b0, 1'b0, 23'h000201, 16'h0000, 2'b11, 16'h2222});
        do_req('{1'b0, 1'b0, 23'h000202, 16'h0000, 2'b11, 16'h3333});
        $display("[TB] b2b readback done");

        // T6 on instance B: one access cycle, no recovery.
        g = 0;
        @(negedge clk);
        while (!b_reqReady && g < 100) begin @(negedge clk); g++; end
        chk("t6_ready", b_reqReady, 1);
        b_reqValid = 1'b1; b_reqWrite = 1'b1; b_reqCfg = 1'b0;
        b_reqAddr  = 23'h5; b_reqWdata = 16'hA5A5; b_reqBe = 2'b11;
        @(posedge clk); #1;
        n = cyc;
        b_reqValid = 1'b0;
        @(negedge clk);
        chk("t6_w_ce", b_mt_ce, 0);
        chk("t6_w_we", b_mt_we, 0);
        chk("t6_w_rspv_early", b_rspValid, 0);
        @(negedge clk);
        chk("t6_w_rspv", b_rspValid, 1);
        chk("t6_w_rsp_cyc", cyc - n, 1);
        chk("t6_w_hold_we", b_mt_we, 1);
        chk("t6_w_ready_hold", b_reqReady, 0);
        @(negedge clk);
        chk("t6_w_ready_after", b_reqReady, 1);
        chk("t6_w_rspv_once", b_rspValid, 0);
        chk("t6_w_ce_idle", b_mt_ce, 1);
        b_reqValid = 1'b1; b_reqWrite = 1'b0;
        b_reqAddr  = 23'h5; b_reqWdata = 16'h0000;
        @(posedge clk); #1;
        b_reqValid = 1'b0;
        @(negedge clk);
        chk("t6_r_oe", b_mt_oe, 0);
        chk("t6_r_ce", b_mt_ce, 0);
        @(negedge clk);
        chk("t6_r_rspv", b_rspValid, 1);
        chk("t6_r_data", b_rspData, 16'hA5A5);
        @(negedge clk);
        chk("t6_r_ready_after", b_reqReady, 1);
        $display("[TB] t6 short-timing write/read done");

        // T1: reset in the middle of a write access.
        wait_ready_a(ok);
        if (ok) begin
            a_reqValid = 1'b1; a_reqWrite = 1'b1; a_reqCfg = 1'b0;
            a_reqAddr  = 23'h3FF; a_reqWdata = 16'hDEAD; a_reqBe = 2'b11;
            @(posedge clk); #1;
            a_reqValid = 1'b0;
            repeat (3) @(negedge clk);
            chk("t1_pre_we", a_mt_we, 0);
            #2;
            a_resetN = 1'b0;
            #1;
            check_reset("t1");
            sb.delete();
            repeat (3) @(negedge clk);
            a_resetN = 1'b1;
            powerup_check("t1");
            $display("[TB] t1 reset mid-write done");
        end

        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("bus_contention", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
